// File: rtl/tone_sequencer.sv
// -----------------------------------------------------------------------------
// tone_sequencer
//
// Note-level controller for the square-wave tone generator. Note commands
// (half-period, duration, amplitude) arrive over a valid/ready handshake into
// a small FIFO. The notes are then played back-to-back. For each note the
// block loads the generator configuration, gates the generator for the
// commanded number of duration ticks, and then inserts a silent gap.
//
// Optional build feature (macro TONE_SEQ_LOOP_EN):
//   Adds a "loop" input. While loop=1, cmd_ready is held low and every LOAD
//   writes the popped entry back at the FIFO tail. The queued sequence then
//   repeats until stop is asserted. Zero-duration entries are still dropped.
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   loop            (TONE_SEQ_LOOP_EN only) replay queued notes indefinitely
//   cmd_valid       command present
//   cmd_ready       FIFO can accept (= !full, independent of a same-cycle pop)
//   cmd_period      half-period in clk cycles, 0 = rest
//   cmd_dur         note length in ticks, 0 = discard
//   cmd_amp         output amplitude
//   stop            synchronous abort: flush FIFO, silence, return to idle
//   gen_load        one-cycle pulse: gen_half_period/gen_amp freshly loaded
//   gen_half_period configured half-period (held between notes)
//   gen_amp         configured amplitude (held between notes)
//   gen_en          generator enable
//   busy            sequencer active or FIFO non-empty
//   note_done       one-cycle pulse when a note (incl. discarded) completes
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tone_sequencer #(
  parameter int PERIOD_W   = 6,
  parameter int DUR_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TICK_DIV   = 1000,
  parameter int GAP_TICKS  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef TONE_SEQ_LOOP_EN
  input  logic                loop,
`endif
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic [DUR_W-1:0]    cmd_dur,
  input  logic [3:0]          cmd_amp,
  input  logic                stop,
  output logic                gen_load,
  output logic [PERIOD_W-1:0] gen_half_period,
  output logic [3:0]          gen_amp,
  output logic                gen_en,
  output logic                busy,
  output logic                note_done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP
  } state_e;

  // FIFO storage
  logic [PERIOD_W-1:0] mem_period [FIFO_DEPTH];
  logic [DUR_W-1:0]    mem_dur    [FIFO_DEPTH];
  logic [3:0]          mem_amp    [FIFO_DEPTH];

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                gen_load_q, gen_load_d;
  logic [PERIOD_W-1:0] gen_half_period_q, gen_half_period_d;
  logic [3:0]          gen_amp_q, gen_amp_d;
  logic                gen_en_q, gen_en_d;
  logic                note_done_q, note_done_d;

  logic                loop_active;
  logic                full, empty, push, pop, requeue, tick;
  logic                mem_we;
  logic [PERIOD_W-1:0] mem_wperiod;
  logic [DUR_W-1:0]    mem_wdur;
  logic [3:0]          mem_wamp;
  logic [PERIOD_W-1:0] head_period;
  logic [DUR_W-1:0]    head_dur;
  logic [3:0]          head_amp;

`ifdef TONE_SEQ_LOOP_EN
  assign loop_active = loop;
`else
  assign loop_active = 1'b0;
`endif

  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  // In loop mode the FIFO is closed to new commands so the replayed
  // sequence cannot be disturbed.
  assign cmd_ready   = !full && !loop_active;
  assign push        = cmd_valid && cmd_ready && !stop;
  assign head_period = mem_period[rd_ptr_q];
  assign head_dur    = mem_dur[rd_ptr_q];
  assign head_amp    = mem_amp[rd_ptr_q];
  assign tick        = (pre_q == PRE_W'(TICK_DIV - 1));

  // NOTE: every signal assigned in this block gets a default first, so that
  // no path leaves a value unassigned and infers a latch.
  always_comb begin
    state_d           = state_q;
    wr_ptr_d          = wr_ptr_q;
    rd_ptr_d          = rd_ptr_q;
    count_d           = count_q;
    pre_d             = pre_q;
    dur_d             = dur_q;
    gap_d             = gap_q;
    gen_load_d        = 1'b0;
    gen_half_period_d = gen_half_period_q;
    gen_amp_d         = gen_amp_q;
    gen_en_d          = gen_en_q;
    note_done_d       = 1'b0;
    pop               = 1'b0;
    requeue           = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_LOAD;
      end

      S_LOAD: begin
        pop               = 1'b1;
        gen_load_d        = 1'b1;
        gen_half_period_d = head_period;
        gen_amp_d         = head_amp;
        if (head_dur == '0) begin
          note_done_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          dur_d    = head_dur;
          pre_d    = '0;
          gen_en_d = (head_period != '0);
          requeue  = loop_active;
          state_d  = S_PLAY;
        end
      end

      S_PLAY: begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        if (tick) begin
          dur_d = dur_q - DUR_W'(1);
          if (dur_q == DUR_W'(1)) begin
            gen_en_d = 1'b0;
            if (GAP_TICKS > 0) begin
              gap_d   = GAP_W'(GAP_TICKS);
              state_d = S_GAP;
            end else begin
              note_done_d = 1'b1;
              state_d     = S_IDLE;
            end
          end
        end
      end

      S_GAP: begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        if (tick) begin
          gap_d = gap_q - GAP_W'(1);
          if (gap_q == GAP_W'(1)) begin
            note_done_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A replayed entry occupies the tail slot that a push would otherwise
    // use. Both cannot happen together because cmd_ready is low in loop mode.
    mem_we      = push || requeue;
    mem_wperiod = requeue ? head_period : cmd_period;
    mem_wdur    = requeue ? head_dur    : cmd_dur;
    mem_wamp    = requeue ? head_amp    : cmd_amp;
    if (mem_we) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop && !requeue})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // stop overrides every other event, including a same-cycle push.
    if (stop) begin
      state_d     = S_IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      pre_d       = '0;
      dur_d       = '0;
      gap_d       = '0;
      gen_load_d  = 1'b0;
      gen_en_d    = 1'b0;
      note_done_d = 1'b0;
      mem_we      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      pre_q             <= '0;
      dur_q             <= '0;
      gap_q             <= '0;
      gen_load_q        <= 1'b0;
      gen_half_period_q <= '0;
      gen_amp_q         <= '0;
      gen_en_q          <= 1'b0;
      note_done_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      count_q           <= count_d;
      pre_q             <= pre_d;
      dur_q             <= dur_d;
      gap_q             <= gap_d;
      gen_load_q        <= gen_load_d;
      gen_half_period_q <= gen_half_period_d;
      gen_amp_q         <= gen_amp_d;
      gen_en_q          <= gen_en_d;
      note_done_q       <= note_done_d;
    end
  end

  // NOTE: the FIFO storage has no reset. Entries are only read after they
  // have been written, because count_q gates every read, so clearing the
  // array would buy nothing.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_period[wr_ptr_q] <= mem_wperiod;
      mem_dur[wr_ptr_q]    <= mem_wdur;
      mem_amp[wr_ptr_q]    <= mem_wamp;
    end
  end

  assign gen_load        = gen_load_q;
  assign gen_half_period = gen_half_period_q;
  assign gen_amp         = gen_amp_q;
  assign gen_en          = gen_en_q;
  assign note_done       = note_done_q;
  assign busy            = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_tone_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tone_sequencer
//
// Directed testbench for tone_sequencer, configured with TICK_DIV=4 and
// GAP_TICKS=1. Inputs are driven 1 ns after each rising edge, and outputs are
// sampled at the same point. Expected values are hand-derived constants.
// Scenarios: reset, single note timing, FIFO full/ordering, zero-duration and
// rest notes, stop abort, asynchronous reset mid-gap, and loop mode (only
// when TONE_SEQ_LOOP_EN is defined).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_tone_sequencer;

  localparam int PERIOD_W = 6;
  localparam int DUR_W    = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                loop;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [PERIOD_W-1:0] cmd_period;
  logic [DUR_W-1:0]    cmd_dur;
  logic [3:0]          cmd_amp;
  logic                stop;
  logic                gen_load;
  logic [PERIOD_W-1:0] gen_half_period;
  logic [3:0]          gen_amp;
  logic                gen_en;
  logic                busy;
  logic                note_done;

  int tests  = 0;
  int failed = 0;
  int n;
  logic seen_a, seen_b, seen_c;

  tone_sequencer #(
    .PERIOD_W  (PERIOD_W),
    .DUR_W     (DUR_W),
    .FIFO_DEPTH(4),
    .TICK_DIV  (4),
    .GAP_TICKS (1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef TONE_SEQ_LOOP_EN
    .loop           (loop),
`endif
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_period     (cmd_period),
    .cmd_dur        (cmd_dur),
    .cmd_amp        (cmd_amp),
    .stop           (stop),
    .gen_load       (gen_load),
    .gen_half_period(gen_half_period),
    .gen_amp        (gen_amp),
    .gen_en         (gen_en),
    .busy           (busy),
    .note_done      (note_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        failed++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [PERIOD_W-1:0] p, input logic [DUR_W-1:0] d,
                      input logic [3:0] a);
    check("push_ready", 32'(cmd_ready), 1);
    cmd_valid  = 1'b1;
    cmd_period = p;
    cmd_dur    = d;
    cmd_amp    = a;
    step();
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_load(input string tag, input int budget);
    int k;
    k = 0;
    while (gen_load !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(k < budget), 1);
  endtask

  initial begin
    rst_n      = 1'b0;
    loop       = 1'b0;
    cmd_valid  = 1'b0;
    cmd_period = '0;
    cmd_dur    = '0;
    cmd_amp    = '0;
    stop       = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // ---- reset values ----
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_gen_load", 32'(gen_load), 0);
    check("rst_gen_en", 32'(gen_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_note_done", 32'(note_done), 0);
    check("rst_period", 32'(gen_half_period), 0);
    check("rst_amp", 32'(gen_amp), 0);
    rst_n = 1'b1;
    step();

    // ---- basic note: period 16, dur 3, amp F ----
    push(6'd16, 8'd3, 4'hF);               // accepted at edge N
    check("basic_busy", 32'(busy), 1);
    check("basic_load_n", 32'(gen_load), 0);
    step();                                 // N+1: LOAD
    check("basic_load_n1", 32'(gen_load), 0);
    step();                                 // N+2
    check("basic_load", 32'(gen_load), 1);
    check("basic_period", 32'(gen_half_period), 16);
    check("basic_amp", 32'(gen_amp), 4'hF);
    check("basic_en_on", 32'(gen_en), 1);
    n = 0;
    while (gen_en === 1'b1 && n < 100) begin
      n++;
      step();
    end
    check("basic_en_cycles", 32'(n), 12);
    check("basic_gap_busy", 32'(busy), 1);
    check("basic_gap_done", 32'(note_done), 0);
    repeat (3) step();
    check("basic_gap_end_done", 32'(note_done), 0);
    check("basic_gap_end_busy", 32'(busy), 1);
    step();
    check("basic_note_done", 32'(note_done), 1);
    check("basic_busy_low", 32'(busy), 0);
    check("basic_hold_period", 32'(gen_half_period), 16);
    step();
    check("basic_done_pulse", 32'(note_done), 0);

    // ---- FIFO full and ordering ----
    push(6'd1, 8'd3, 4'h0);                 // note X keeps the sequencer busy
    step();
    step();
    check("ff_x_load", 32'(gen_load), 1);
    push(6'd2, 8'd1, 4'h1);
    push(6'd3, 8'd1, 4'h2);
    push(6'd4, 8'd1, 4'h3);
    push(6'd5, 8'd1, 4'h4);
    cmd_valid  = 1'b1;                      // fifth command, held until accepted
    cmd_period = 6'd6;
    cmd_dur    = 8'd1;
    cmd_amp    = 4'h5;
    check("ff_full_ready", 32'(cmd_ready), 0);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("ff_blocked_cycles", 32'(n), 14);
    check("ff_pop_load", 32'(gen_load), 1);
    check("ff_a_period", 32'(gen_half_period), 2);
    check("ff_a_amp", 32'(gen_amp), 1);
    step();                                 // fifth command accepted here
    cmd_valid = 1'b0;
    wait_load("ff_wait_b", 100);
    check("ff_b_period", 32'(gen_half_period), 3);
    step();
    wait_load("ff_wait_c", 100);
    check("ff_c_period", 32'(gen_half_period), 4);
    step();
    wait_load("ff_wait_d", 100);
    check("ff_d_period", 32'(gen_half_period), 5);
    step();
    wait_load("ff_wait_e", 100);
    check("ff_e_period", 32'(gen_half_period), 6);
    check("ff_e_amp", 32'(gen_amp), 5);
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    check("ff_idle", 32'(n < 100), 1);
    step();

    // ---- zero duration: loaded, done, never enabled ----
    push(6'd7, 8'd0, 4'h3);
    step();
    step();
    check("d0_load", 32'(gen_load), 1);
    check("d0_done", 32'(note_done), 1);
    check("d0_en", 32'(gen_en), 0);
    check("d0_period", 32'(gen_half_period), 7);
    step();
    check("d0_load_pulse", 32'(gen_load), 0);
    check("d0_done_pulse", 32'(note_done), 0);
    check("d0_busy", 32'(busy), 0);

    // ---- rest: period 0, dur 2 ----
    push(6'd0, 8'd2, 4'h5);
    step();
    step();
    check("rest_load", 32'(gen_load), 1);
    check("rest_en", 32'(gen_en), 0);
    check("rest_amp", 32'(gen_amp), 5);
    seen_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (gen_en !== 1'b0) seen_a = 1'b1;
    end
    check("rest_en_never", 32'(seen_a), 0);
    check("rest_done", 32'(note_done), 1);
    step();

    // ---- stop during PLAY with two queued ----
    push(6'd9, 8'd5, 4'h1);
    step();
    step();
    check("stop_en_on", 32'(gen_en), 1);
    push(6'd10, 8'd1, 4'h2);
    push(6'd12, 8'd1, 4'h3);
    stop       = 1'b1;
    cmd_valid  = 1'b1;
    cmd_period = 6'd11;
    cmd_dur    = 8'd1;
    check("stop_ready_before", 32'(cmd_ready), 1);
    step();
    stop      = 1'b0;
    cmd_valid = 1'b0;
    check("stop_en_off", 32'(gen_en), 0);
    check("stop_busy", 32'(busy), 0);
    check("stop_no_done", 32'(note_done), 0);
    check("stop_ready", 32'(cmd_ready), 1);
    seen_a = 1'b0;
    seen_b = 1'b0;
    seen_c = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (note_done !== 1'b0) seen_a = 1'b1;
      if (gen_load !== 1'b0)  seen_b = 1'b1;
      if (busy !== 1'b0)      seen_c = 1'b1;
    end
    check("stop_never_done", 32'(seen_a), 0);
    check("stop_never_load", 32'(seen_b), 0);
    check("stop_stays_idle", 32'(seen_c), 0);
    check("stop_hold_period", 32'(gen_half_period), 9);

    // ---- asynchronous reset in GAP ----
    push(6'd13, 8'd1, 4'h2);
    step();
    step();
    check("ar_load", 32'(gen_load), 1);
    repeat (5) step();                      // two cycles into GAP
    check("ar_in_gap_busy", 32'(busy), 1);
    check("ar_in_gap_en", 32'(gen_en), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_busy", 32'(busy), 0);
    check("ar_period", 32'(gen_half_period), 0);
    check("ar_amp", 32'(gen_amp), 0);
    check("ar_ready", 32'(cmd_ready), 1);
    check("ar_en", 32'(gen_en), 0);
    check("ar_done", 32'(note_done), 0);
    #2;
    rst_n = 1'b1;
    step();
    push(6'd20, 8'd1, 4'h4);
    step();
    step();
    check("ar_new_load", 32'(gen_load), 1);
    check("ar_new_period", 32'(gen_half_period), 20);
    check("ar_new_amp", 32'(gen_amp), 4);
    n = 0;
    while (gen_en === 1'b1 && n < 100) begin
      n++;
      step();
    end
    check("ar_new_en_cycles", 32'(n), 4);
    n = 0;
    while (note_done !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("ar_new_done", 32'(n), 4);
    step();

`ifdef TONE_SEQ_LOOP_EN
    // ---- loop mode: 1,2,1,2,1,2 then stop ----
    push(6'd30, 8'd2, 4'h1);                // popped with loop=0, plays once
    step();
    step();
    check("lp_x_load", 32'(gen_load), 1);
    push(6'd21, 8'd1, 4'h6);
    push(6'd22, 8'd1, 4'h7);
    loop = 1'b1;
    #1;
    check("lp_ready_low", 32'(cmd_ready), 0);
    for (int k = 0; k < 6; k++) begin
      step();
      wait_load("lp_wait", 100);
      check("lp_period", 32'(gen_half_period), (k % 2 == 0) ? 21 : 22);
      check("lp_ready", 32'(cmd_ready), 0);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("lp_stop_busy", 32'(busy), 0);
    check("lp_stop_en", 32'(gen_en), 0);
    loop = 1'b0;
    #1;
    check("lp_ready_back", 32'(cmd_ready), 1);
    seen_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (gen_load !== 1'b0) seen_a = 1'b1;
    end
    check("lp_flushed", 32'(seen_a), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
